// File: rtl/uart_pkg.sv
// Purpose: shared UART subsystem definitions (state encodings, default clocking, frame shape).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: uart_state_t (ST_IDLE/ST_START/ST_DATA/ST_STOP), DEFAULT_BOARD_CLOCK,
//   DEFAULT_BAUD_RATE, FRAME_BITS, DATA_BITS, baud_period() helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int DEFAULT_BOARD_CLOCK = 1_000_000;
  localparam int DEFAULT_BAUD_RATE   = 9600;

  // 8N1: start + 8 data + stop
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  // Clock cycles per bit; truncating division matches the receive path.
  function automatic int baud_period(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Purpose: round-robin pick of one request, searching upward from ptr with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the grant with its own ready condition.
// Ports: req (masked request vector), ptr (highest-priority index),
//   gnt (one-hot grant), gnt_idx (binary index of gnt), gnt_vld (any request present).
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the last hit written is the
  // one closest to ptr; avoids a break and keeps the loop statically unrolled.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        gnt_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Purpose: shares one 8N1 txd line among NUM_REQ byte producers, round-robin per frame.
// Latency: start bit begins the cycle after the transfer; frames repeat every 10*BAUD_PERIOD+1 cycles.
// Backpressure: req_ready is one-hot and only asserted in ST_IDLE; everyone else waits.
// Ports: clk_1MHz, rst_n (async active-low), req_valid/req_data/req_last (per requester),
//   req_ready (one-hot grant), txd (idle high), busy (frame in flight), grant_id (current owner).
// Option: define UART_TX_SCHED_LOCK_EN to hold the grant on a requester until req_last.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  BOARD_CLOCK = DEFAULT_BOARD_CLOCK,
  parameter int  BAUD_RATE   = DEFAULT_BAUD_RATE,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk_1MHz,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 txd,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_id
);

  localparam int BAUD_PERIOD = baud_period(BOARD_CLOCK, BAUD_RATE);
  localparam int CNT_W       = $clog2(BAUD_PERIOD);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_PERIOD - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

  uart_state_t state, state_nxt;

  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [IDX_W-1:0]     ptr;

  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_vld;
  logic [7:0]           sel_byte;
  logic                 xfer;
  logic                 xfer_last;
  logic                 baud_done;

`ifdef UART_TX_SCHED_LOCK_EN
  logic             lock_vld;
  logic [IDX_W-1:0] lock_id;

  // While a packet is open only its owner may compete.
  always_comb begin
    elig = req_valid;
    if (lock_vld) begin
      elig = req_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << lock_id);
    end
  end

  assign xfer_last = req_last[arb_idx];

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld <= 1'b0;
      lock_id  <= '0;
    end else if (xfer) begin
      lock_vld <= !xfer_last;
      lock_id  <= arb_idx;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign elig        = req_valid;
  assign xfer_last   = 1'b1;
`endif

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (elig),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Byte mux on the arbiter index.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_byte = req_data[8*i +: 8];
      end
    end
  end

  assign baud_done = (baud_cnt == BAUD_LAST);

  // Next-state and outputs. req_ready is gated by rst_n so it reads zero
  // throughout reset even if producers are already asserting valid.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    xfer      = 1'b0;
    txd       = 1'b1;
    busy      = 1'b1;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (rst_n) begin
          req_ready = arb_gnt;
          xfer      = arb_vld;
        end
        if (xfer) state_nxt = ST_START;
      end
      ST_START: begin
        txd = 1'b0;
        if (baud_done) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        txd = shreg[0];
        if (baud_done && bit_cnt == BIT_LAST) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (baud_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      grant_id <= '0;
      ptr      <= '0;
    end else begin
      // Bit timer restarts on every state change and at each bit boundary in ST_DATA.
      if (state_nxt != state || state == ST_IDLE || baud_done) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      if (state != ST_DATA) begin
        bit_cnt <= '0;
      end else if (baud_done) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (xfer) begin
        shreg    <= sel_byte;
        grant_id <= arb_idx;
      end else if (state == ST_DATA && baud_done) begin
        shreg <= shreg >> 1;
      end

      // Pointer only moves when a packet closes (always, when locking is not built).
      if (xfer && xfer_last) begin
        ptr <= (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Purpose: directed self-checking bench for uart_tx_scheduler at default parameters.
// Latency: checks start bit one cycle after transfer and 1041-cycle frame spacing.
// Backpressure: checks req_ready is a one-cycle one-hot pulse only in idle.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int BP = 104;  // 1_000_000 / 9600, truncated

  logic        clk_1MHz = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        txd;
  logic        busy;
  logic [1:0]  grant_id;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk_1MHz = ~clk_1MHz;
  always @(posedge clk_1MHz) cyc <= cyc + 1;

  uart_tx_scheduler dut (
    .clk_1MHz  (clk_1MHz),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .txd       (txd),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial begin
    repeat (40000) @(posedge clk_1MHz);
    $display("FAIL watchdog: observed no end of test, expected finish within 40000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_1MHz);
    #1;
  endtask

  function automatic logic [31:0] put_byte(input logic [31:0] vec, input int i, input logic [7:0] b);
    logic [31:0] v;
    v = vec;
    v[8*i +: 8] = b;
    return v;
  endfunction

  // Waits (bounded) for a transfer in the current or a later idle cycle.
  task automatic wait_transfer(input int exp_id, input string tag, output int waited);
    waited = 0;
    #1;
    while ((req_ready & req_valid) == 4'b0000 && waited < 3000) begin
      step();
      waited++;
    end
    chk({tag, " xfer_seen"}, 32'((req_ready & req_valid) != 4'b0000), 32'd1);
    chk({tag, " ready_onehot"}, 32'(req_ready), 32'(4'b0001 << exp_id));
    chk({tag, " busy_idle"}, 32'(busy), 32'd0);
  endtask

  // Follows one frame from the cycle after the transfer to the first idle cycle.
  task automatic check_frame(input logic [7:0] b, input int id, input string tag,
                             input logic [3:0] va, input logic [31:0] da,
                             input logic [3:0] la, output int st);
    int   pos;
    logic exp_txd;
    st = 0;
    for (int c = 1; c <= 10*BP; c++) begin
      step();
      pos = (c - 1) / BP;
      if (c == 1) begin
        st = cyc;
        chk({tag, " grant_id"}, 32'(grant_id), 32'(id));
      end
      if ((c - 1) % BP == 0 || c % BP == 0) begin
        if (pos == 0)      exp_txd = 1'b0;
        else if (pos == 9) exp_txd = 1'b1;
        else               exp_txd = b[3'(pos - 1)];
        chk($sformatf("%s txd c%0d", tag, c), 32'(txd), 32'(exp_txd));
        chk($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'd1);
        chk($sformatf("%s ready c%0d", tag, c), 32'(req_ready), 32'd0);
      end
      if (c == 1) begin
        req_valid = va;
        req_data  = da;
        req_last  = la;
      end
    end
    step();
    chk({tag, " busy_end"}, 32'(busy), 32'd0);
    chk({tag, " txd_end"}, 32'(txd), 32'd1);
  endtask

  initial begin
    int          w;
    int          st;
    int          prev_st;
    logic [3:0]  nv;
    logic [31:0] nd;
    logic [3:0]  nl;
    logic [7:0]  cb [4];
    int          ord [4];
    logic [7:0]  ob [4];
    logic [7:0]  b1 [3];
    int          n1;

    // Reset state
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    req_last  = 4'b1111;
    step();
    chk("rst txd", 32'(txd), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst grant_id", 32'(grant_id), 32'd0);
    chk("rst ready", 32'(req_ready), 32'd0);
    step();
    rst_n = 1'b1;

    // Nothing pending: line stays idle
    repeat (20) step();
    chk("idle txd", 32'(txd), 32'd1);
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle ready", 32'(req_ready), 32'd0);

    // Contention: all four at once from ptr=0
    cb[0] = 8'h11; cb[1] = 8'h22; cb[2] = 8'h33; cb[3] = 8'h44;
    req_valid = 4'b1111;
    req_data  = 32'h44332211;
    nv        = 4'b1111;
    prev_st   = 0;
    for (int f = 0; f < 4; f++) begin
      wait_transfer(f, $sformatf("cont%0d", f), w);
      nv[f] = 1'b0;
      check_frame(cb[f], f, $sformatf("cont%0d", f), nv, req_data, 4'b1111, st);
      if (f > 0) chk($sformatf("cont%0d spacing", f), 32'(st - prev_st), 32'd1041);
      prev_st = st;
    end

    // Single byte 0xA5 from requester 0
    req_valid = 4'b0001;
    req_data  = put_byte(32'h0, 0, 8'hA5);
    wait_transfer(0, "single", w);
    check_frame(8'hA5, 0, "single", 4'b0000, req_data, 4'b1111, st);

    // Handshake: requester 1 held valid during requester 0's frame
    req_valid = 4'b0001;
    req_data  = put_byte(32'h0, 0, 8'h5A);
    wait_transfer(0, "hs0", w);
    check_frame(8'h5A, 0, "hs0", 4'b0010, put_byte(req_data, 1, 8'h3C), 4'b1111, st);
    wait_transfer(1, "hs1", w);
    chk("hs1 first_idle", 32'(w), 32'd0);
    check_frame(8'h3C, 1, "hs1", 4'b0000, put_byte(req_data, 1, 8'hFF), 4'b1111, st);

    // Fairness: last grant 2, then 0 and 3 pending -> 3 first, then 0
    req_valid = 4'b0100;
    req_data  = put_byte(32'h0, 2, 8'h81);
    wait_transfer(2, "fair2", w);
    nd = put_byte(put_byte(req_data, 3, 8'hC3), 0, 8'h24);
    check_frame(8'h81, 2, "fair2", 4'b1001, nd, 4'b1111, st);
    wait_transfer(3, "fair3", w);
    check_frame(8'hC3, 3, "fair3", 4'b0001, nd, 4'b1111, st);
    wait_transfer(0, "fair0", w);
    check_frame(8'h24, 0, "fair0", 4'b0000, nd, 4'b1111, st);

    // Packet of three bytes from requester 1 with requester 0 pending
    b1[0] = 8'h61; b1[1] = 8'h62; b1[2] = 8'h63;
`ifdef UART_TX_SCHED_LOCK_EN
    ord[0] = 1; ord[1] = 1; ord[2] = 1; ord[3] = 0;
    ob[0] = 8'h61; ob[1] = 8'h62; ob[2] = 8'h63; ob[3] = 8'h50;
`else
    ord[0] = 1; ord[1] = 0; ord[2] = 1; ord[3] = 1;
    ob[0] = 8'h61; ob[1] = 8'h50; ob[2] = 8'h62; ob[3] = 8'h63;
`endif
    nv = 4'b0011;
    nd = put_byte(put_byte(32'h0, 0, 8'h50), 1, 8'h61);
    nl = 4'b1101;
    req_valid = nv;
    req_data  = nd;
    req_last  = nl;
    n1 = 0;
    for (int f = 0; f < 4; f++) begin
      wait_transfer(ord[f], $sformatf("lock%0d", f), w);
      if (ord[f] == 1) begin
        n1++;
        if (n1 < 3) begin
          nd    = put_byte(nd, 1, b1[n1]);
          nl[1] = (n1 == 2);
        end else begin
          nv[1] = 1'b0;
        end
      end else begin
        nv[0] = 1'b0;
      end
      check_frame(ob[f], ord[f], $sformatf("lock%0d", f), nv, nd, nl, st);
    end

    // Reset during data bit 4 of a frame from requester 2, then 1 and 3 pending
    req_last  = 4'b1111;
    req_valid = 4'b0100;
    req_data  = put_byte(32'h0, 2, 8'h0F);
    wait_transfer(2, "rstf", w);
    for (int c = 1; c <= 5*BP + BP/2; c++) begin
      step();
      if (c == 1) begin
        req_valid = 4'b1010;
        req_data  = put_byte(put_byte(req_data, 1, 8'h7E), 3, 8'h99);
      end
    end
    chk("rstf bit4 txd", 32'(txd), 32'd0);
    chk("rstf bit4 busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst txd", 32'(txd), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst grant_id", 32'(grant_id), 32'd0);
    chk("midrst ready", 32'(req_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    wait_transfer(1, "postrst", w);
    check_frame(8'h7E, 1, "postrst", 4'b0000, req_data, 4'b1111, st);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
